// File: rtl/if_stage_buffered.sv
// Buffered instruction fetch stage: credit-limited sequential requests to a variable-latency
// in-order memory, a DEPTH-entry fetch queue toward decode, and redirect with stale-response discard.
module if_stage_buffered #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                PC_STEP  = 4,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BrTaken,
  input  logic [ADDR_W-1:0]  branch,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  address
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]      count_q, count_d, inflight_q, inflight_d, stale_q, stale_d;
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]      pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
  logic [INSTR_W-1:0] qi_q [DEPTH];
  logic [ADDR_W-1:0]  qp_q [DEPTH];
  logic [ADDR_W-1:0]  pf_q [DEPTH];

  logic [CW:0] occ_s;
  logic        accept_s, rsp_s, push_s, pop_s, nonempty_s;

  // Occupancy counts queued entries plus live (non-stale) requests so a response always has a slot.
  assign occ_s          = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, stale_q};
  assign imem_req_valid = reset & ~BrTaken & (occ_s < DEPTH_OCC) & (inflight_q < DEPTH_CNT);
  assign accept_s       = imem_req_valid & imem_req_ready;
  assign rsp_s          = reset & imem_rsp_valid;
  assign push_s         = rsp_s & ~BrTaken & (stale_q == {CW{1'b0}});
  assign nonempty_s     = (count_q != {CW{1'b0}});
  assign instr_valid    = reset & ~BrTaken & nonempty_s;
  assign pop_s          = instr_valid & instr_ready;

  assign imem_addr   = pc_q;
  assign instruction = nonempty_s ? qi_q[head_q] : {INSTR_W{1'b0}};
  assign address     = nonempty_s ? qp_q[head_q] : {ADDR_W{1'b0}};

  // Next-state for PC, queue pointers and the three counters.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    stale_d    = stale_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = inflight_q + CW'(accept_s) - CW'(rsp_s);
    pf_wr_d    = accept_s ? pf_wr_q + AW'(1) : pf_wr_q;
    pf_rd_d    = rsp_s ? pf_rd_q + AW'(1) : pf_rd_q;
    if (BrTaken) begin
      pc_d    = branch;
      count_d = {CW{1'b0}};
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      stale_d = inflight_q - CW'(rsp_s);
    end else begin
      pc_d    = accept_s ? pc_q + ADDR_W'(PC_STEP) : pc_q;
      tail_d  = push_s ? tail_q + AW'(1) : tail_q;
      head_d  = pop_s ? head_q + AW'(1) : head_q;
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (rsp_s && (stale_q != {CW{1'b0}})) begin
        stale_d = stale_q - CW'(1);
      end else begin
        stale_d = stale_q;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      count_q    <= {CW{1'b0}};
      inflight_q <= {CW{1'b0}};
      stale_q    <= {CW{1'b0}};
      head_q     <= {AW{1'b0}};
      tail_q     <= {AW{1'b0}};
      pf_rd_q    <= {AW{1'b0}};
      pf_wr_q    <= {AW{1'b0}};
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pf_rd_q    <= pf_rd_d;
      pf_wr_q    <= pf_wr_d;
    end
  end

  // Data storage needs no reset; validity is carried by the counters and pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      qi_q[tail_q] <= imem_rsp_data;
      qp_q[tail_q] <= pf_q[pf_rd_q];
    end
    if (accept_s) begin
      pf_q[pf_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_if_stage_buffered.sv
// Self-checking bench for if_stage_buffered: queue-based reference model compared every cycle,
// fixed-latency in-order memory model, and directed scenarios with literal expectations.
module tb_if_stage_buffered;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, BrTaken, imem_req_ready, imem_rsp_valid, instr_ready;
  logic [63:0] branch;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, instr_valid;
  logic [63:0] imem_addr, address;
  logic [31:0] instruction;

  always #5 clk = ~clk;

  if_stage_buffered dut (
    .clk(clk), .reset(reset), .BrTaken(BrTaken), .branch(branch),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .address(address)
  );

  typedef struct packed { logic [63:0] pc; logic stale; } infl_t;
  typedef struct packed { logic [31:0] ins; logic [63:0] pc; } qe_t;
  typedef struct packed { logic [63:0] a; int due; } me_t;

  int          n_assert = 0, n_fail = 0, cyc = 0, lat = 1, acc_cnt = 0;
  logic [63:0] m_pc = 64'h0;
  infl_t       infl[$];
  qe_t         mq[$];
  me_t         mem_q[$];
  logic [63:0] dec_log[$];
  logic [31:0] dat_log[$];

  function automatic logic [31:0] memf(input logic [63:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [63:0] dl(input int i);
    return (i < dec_log.size()) ? dec_log[i] : 64'hDEAD_DEAD;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive memory response, compare against the model, then advance model and memory.
  task automatic step();
    int          live;
    logic        e_rv, e_iv, s_acc;
    logic [63:0] s_addr, e_adr;
    logic [31:0] e_ins;
    infl_t       t;
    qe_t         q;
    me_t         m;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mem_q[0].a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    live = 0;
    for (int i = 0; i < infl.size(); i++) if (!infl[i].stale) live++;
    e_rv  = reset && !BrTaken && (mq.size() + live < DEPTH) && (infl.size() < DEPTH);
    e_iv  = reset && !BrTaken && (mq.size() != 0);
    e_ins = (mq.size() != 0) ? mq[0].ins : 32'h0;
    e_adr = (mq.size() != 0) ? mq[0].pc : 64'h0;
    chk("imem_req_valid", 64'(imem_req_valid), 64'(e_rv));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 64'(instr_valid), 64'(e_iv));
    chk("instruction", 64'(instruction), 64'(e_ins));
    chk("address", address, e_adr);
    s_acc  = imem_req_valid & imem_req_ready;
    s_addr = imem_addr;
    if (s_acc) acc_cnt++;
    if (instr_valid && instr_ready) begin
      dec_log.push_back(address);
      dat_log.push_back(instruction);
    end
    @(posedge clk);
    if (!reset) begin
      mem_q.delete();
      m_pc = 64'h0;
      mq.delete();
      infl.delete();
    end else begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (s_acc) begin
        m.a = s_addr; m.due = cyc + lat;
        mem_q.push_back(m);
      end
      if (e_iv && instr_ready) void'(mq.pop_front());
      if (imem_rsp_valid) begin
        chk("rsp_has_request", 64'(infl.size() != 0), 64'h1);
        if (infl.size() != 0) begin
          t = infl.pop_front();
          if (!t.stale && !BrTaken) begin
            chk("queue_no_overflow", 64'(mq.size() < DEPTH), 64'h1);
            q.ins = imem_rsp_data; q.pc = t.pc;
            mq.push_back(q);
          end
        end
      end
      if (BrTaken) begin
        mq.delete();
        for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
        m_pc = branch;
      end else if (e_rv && imem_req_ready) begin
        t.pc = m_pc; t.stale = 1'b0;
        infl.push_back(t);
        m_pc = m_pc + 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int found_stale;
    reset = 1'b0; BrTaken = 1'b0; branch = 64'h0; imem_req_ready = 1'b1;
    instr_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(negedge clk);
    do_reset();
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_instruction", 64'(instruction), 64'h0);
    chk("rst_address", address, 64'h0);
    chk("rst_instr_valid", 64'(instr_valid), 64'h0);

    // Streaming at latency 1: one instruction per cycle after a 2-cycle startup.
    dec_log.delete(); dat_log.delete();
    run(12);
    chk("t1_pops", 64'(dec_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk("t1_addr_seq", dl(i), 64'(i * 4));
    chk("t1_data0", 64'((dat_log.size() > 0) ? dat_log[0] : 32'h0), 64'hBEEF_0000);

    // Decode stalled: exactly DEPTH requests, queue full, then drain in order.
    do_reset();
    instr_ready = 1'b0; acc_cnt = 0;
    run(12);
    chk("t2_accepts", 64'(acc_cnt), 64'd4);
    chk("t2_req_blocked", 64'(imem_req_valid), 64'h0);
    chk("t2_head_addr", address, 64'h0);
    chk("t2_resume_pc", imem_addr, 64'h10);
    instr_ready = 1'b1; dec_log.delete();
    run(6);
    chk("t2_pops", 64'(dec_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("t2_addr_seq", dl(i), 64'(i * 4));

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat = 3;
    run(2);
    BrTaken = 1'b1; branch = 64'h100; dec_log.delete(); dat_log.delete();
    step();
    BrTaken = 1'b0;
    chk("t3_target_pc", imem_addr, 64'h100);
    run(10);
    chk("t3_first_addr", dl(0), 64'h100);
    chk("t3_first_data", 64'((dat_log.size() > 0) ? dat_log[0] : 32'h0), 64'hBFEF_0100);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    lat = 2;
    step();
    imem_req_ready = 1'b0;
    step();
    BrTaken = 1'b1; branch = 64'h200; dec_log.delete();
    step();
    BrTaken = 1'b0; imem_req_ready = 1'b1;
    run(8);
    chk("t4_first_addr", dl(0), 64'h200);
    found_stale = 0;
    for (int i = 0; i < dec_log.size(); i++) if (dec_log[i] < 64'h200) found_stale++;
    chk("t4_no_stale", 64'(found_stale), 64'h0);

    // Memory back-pressure: PC holds, then continues without a skip.
    do_reset();
    lat = 1; dec_log.delete();
    run(4);
    imem_req_ready = 1'b0;
    chk("t5_hold_pc", imem_addr, 64'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_addr_stable", imem_addr, 64'h10);
    end
    imem_req_ready = 1'b1;
    run(6);
    chk("t5_pops", 64'(dec_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t5_addr_seq", dl(i), 64'(i * 4));

    // Reset mid-stream with a full queue.
    do_reset();
    instr_ready = 1'b0;
    run(8);
    chk("t6_full_valid", 64'(instr_valid), 64'h1);
    do_reset();
    chk("t6_instr_valid", 64'(instr_valid), 64'h0);
    chk("t6_addr", imem_addr, 64'h0);
    chk("t6_address", address, 64'h0);
    chk("t6_instruction", 64'(instruction), 64'h0);
    instr_ready = 1'b1; dec_log.delete();
    run(5);
    chk("t6_pops", 64'(dec_log.size()), 64'd3);
    chk("t6_first_addr", dl(0), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage_buffered.md
Name: if_stage_buffered

Overview:
- Parametrised instruction fetch stage that replaces the single-cycle fetch.
- Issues PC-sequential requests to an instruction memory with variable latency and in-order responses.
- Buffers returned instructions in a DEPTH-entry fetch queue and hands them to decode over a valid/ready handshake.
- Supports taken-branch redirect with queue flush and discard of stale in-flight responses.

Parameters:
ADDR_W, 64, width of PC and memory address.
INSTR_W, 32, instruction width.
PC_STEP, 4, sequential PC increment in bytes.
DEPTH, 4, fetch queue entries; power of 2, >= 2; also the max live in-flight requests.
RESET_PC, 0, PC loaded on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset asserted).
BrTaken  input  1  redirect request, single-cycle pulse.
branch  input  ADDR_W  redirect target PC, valid when BrTaken=1.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  ADDR_W  fetch address (current fetch PC).
imem_rsp_valid  input  1  response valid; responses return in request order and cannot be stalled.
imem_rsp_data  input  INSTR_W  response instruction.
instr_valid  output  1  queue head valid to decode.
instr_ready  input  1  decode accepts the head this cycle.
instruction  output  INSTR_W  head instruction; 0 when the queue is empty.
address  output  ADDR_W  PC of the head instruction; 0 when the queue is empty.

Behaviour:
- State:
  - fetch PC.
  - Queue of {instruction, PC}, count 0..DEPTH.
  - inflight: accepted requests not yet answered, 0..DEPTH.
  - stale: the subset of inflight to discard, stale <= inflight.
  - PC FIFO of in-flight request addresses, used to tag responses.
- Reset (reset=0 at an edge):
  - Fetch PC = RESET_PC; queue count, inflight and stale = 0.
  - imem_req_valid=0 and instr_valid=0 while reset=0.
  - imem_addr = RESET_PC; instruction = 0; address = 0.
  - Responses arriving while reset=0 are ignored.
  - Reset mid-operation behaves identically; outstanding memory responses after release must not exist (memory shares the reset).
- Request issue:
  - imem_req_valid = reset & ~BrTaken & (count + (inflight - stale) < DEPTH) & (inflight < DEPTH).
  - Accept = imem_req_valid & imem_req_ready.
  - On accept: fetch PC += PC_STEP (mod 2^ADDR_W, wraps silently); inflight +1; the request PC is pushed to the PC FIFO.
- Response:
  - When imem_rsp_valid: inflight -1, PC FIFO pops.
  - If stale > 0: stale -1, data discarded.
  - Else: {imem_rsp_data, popped PC} is written to the queue tail.
  - The credit rule guarantees the queue never overflows; a push while full is a design error (assert in bench).
- Output:
  - instr_valid = (count != 0) & ~BrTaken.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Zero-latency: a response written at edge N is visible at the head after edge N if the queue was empty.
- Redirect (BrTaken=1 at an edge):
  - Fetch PC <= branch.
  - Queue flushed (count=0); no pop occurs that cycle.
  - No request is issued that cycle.
  - stale <= inflight - imem_rsp_valid; a response arriving in the redirect cycle is dropped.
  - Requests from the target start the following cycle; earliest target instruction at decode is one memory latency later.
  - Back-to-back redirects: the last one wins, and stale accumulates correctly.
- Counters saturate by construction; no wrap is permitted on inflight, stale or count.
- Everything is registered except the combinational imem_req_valid and instr_valid gating.

Test Plan:
- Reset then release, memory with 1-cycle latency, instr_ready=1 -> imem_addr 0,4,8,...; decode sees address 0,4,8 with matching data, one per cycle after a 2-cycle startup.
- instr_ready=0 for 12 cycles, DEPTH=4, latency 1 -> exactly 4 requests accepted, the queue fills to 4, imem_req_valid stays 0 afterwards; on release, 4 pops in order, then fetching resumes at 0x10.
- Memory latency 3, 2 requests in flight, BrTaken with branch=0x100 -> both old responses dropped, queue empty, next issued imem_addr=0x100, and the first decoded address is 0x100.
- BrTaken in the same cycle as imem_rsp_valid with inflight=1 -> response dropped, stale=0 afterwards, and no stale entry ever reaches decode.
- imem_req_ready held 0 for 5 cycles -> imem_addr is stable at the same PC and the PC does not advance; after ready rises, the sequence continues without skip.
- reset=0 asserted for 1 cycle mid-stream with a full queue -> next cycle instr_valid=0, count=0, imem_addr=RESET_PC; fetching restarts from RESET_PC.
